// File: rtl/mul_tree_sched_pkg.sv
// mul_tree_sched_pkg: shared mode encodings, bf16 constant, FSM state type and packing helpers
package mul_tree_sched_pkg;
  localparam logic [1:0] TWO_IN = 2'd0, THREE_IN = 2'd1, FOUR_IN = 2'd2, SIX_IN = 2'd3;
  localparam logic [15:0] BF16_ONE = 16'h3F80;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  function automatic logic nin_ok(input logic [2:0] nin);
    return nin >= 3'd2 && nin <= 3'd6;
  endfunction
  // illegal counts report the current mode so they never force a drain
  function automatic logic [1:0] req_mode(input logic [2:0] nin, input logic [1:0] cur);
    return nin == 3'd2 ? TWO_IN :
           (nin == 3'd3 || nin == 3'd4) ? FOUR_IN :
           (nin == 3'd5 || nin == 3'd6) ? SIX_IN : cur;
  endfunction
  // odd operand counts are padded with 1.0 so the product is unchanged
  function automatic logic [127:0] pack_ops(input logic [2:0] nin, input logic [95:0] ops);
    return nin == 3'd2 ? {96'd0, ops[31:0]} :
           nin == 3'd3 ? {64'd0, BF16_ONE, ops[47:0]} :
           nin == 3'd4 ? {64'd0, ops[63:0]} :
           nin == 3'd5 ? {BF16_ONE, BF16_ONE, BF16_ONE, ops[79:0]} :
           nin == 3'd6 ? {BF16_ONE, BF16_ONE, ops[95:0]} : 128'd0;
  endfunction
endpackage

// File: rtl/mul_tree_sched_tag_fifo.sv
// sched_tag_fifo: DEPTH x TAG_W synchronous tag FIFO
//   push/din write, pop/dout read head, flush clears, full/empty/count status
module sched_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [TAG_W-1:0]         din,
  output logic [TAG_W-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [TAG_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic pw, pr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign pw = push && !full;
  assign pr = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(pw);
      rp <= rp + AW'(pr);
      count <= count + (AW+1)'(pw) - (AW+1)'(pr);
    end
  always_ff @(posedge clk)
    if (pw) mem[wp] <= din;
endmodule

// File: rtl/mul_tree_sched.sv
// mul_tree_sched: issue scheduler for the bf16 product-node multiplier tree
//   job_*  : job offer (valid/ready, operand count, 6x bf16 operands, tag)
//   mul_*  : registered tree operand bus, issue strobe and tree mode
//   tree_* : tree outputs; lane 0 carries the product in every mode
//   res_*  : in-order results with tag, no backpressure
//   busy   : jobs in flight; err: one-cycle pulse on illegal job, stray strobe or watchdog
//   MUL_TREE_SCHED_WDOG_EN enables a watchdog that flushes after WDOG_CYC stalled cycles
module mul_tree_sched
  import mul_tree_sched_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int DEPTH = 16,
  parameter int WDOG_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [2:0]        job_nin,
  input  logic [95:0]       job_ops,
  input  logic [TAG_W-1:0]  job_tag,
  output logic [127:0]      mul_ins,
  output logic              mul_stb,
  output logic [1:0]        mode,
  input  logic [63:0]       tree_out,
  input  logic [3:0]        tree_stbs,
  output logic              res_valid,
  output logic [15:0]       res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic              busy,
  output logic              err
);
  localparam int AW = $clog2(DEPTH);
  state_t state, nxt;
  logic [AW:0] cnt, nxt_cnt;
  logic [TAG_W-1:0] head;
  logic [1:0] rmode;
  logic full, empty, legal, acc, push, pop, stray, wd_fire, unused_ok;
  assign legal = nin_ok(job_nin);
  assign rmode = req_mode(job_nin, mode);
  assign job_ready = !full && state != DRAIN && (cnt == '0 || rmode == mode) && !wd_fire;
  assign acc = job_valid && job_ready;
  assign push = acc && legal;
  assign pop = tree_stbs[0] && cnt != '0;
  assign stray = tree_stbs[0] && cnt == '0;
  assign busy = cnt != '0;
  assign nxt_cnt = cnt + (AW+1)'(push) - (AW+1)'(pop);
  // a waiting job with a different mode locks out new issues until the tree empties
  assign nxt = (wd_fire || nxt_cnt == '0) ? IDLE :
               (state == DRAIN || (job_valid && cnt != '0 && rmode != mode)) ? DRAIN : RUN;
  assign unused_ok = ^{tree_out[63:16], tree_stbs[3:1], empty};
`ifdef MUL_TREE_SCHED_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);
  logic [WW-1:0] wcnt;
  assign wd_fire = cnt != '0 && !pop && wcnt == WW'(WDOG_CYC - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) wcnt <= '0;
    else wcnt <= (pop || cnt == '0 || wd_fire) ? '0 : wcnt + 1'b1;
`else
  assign wd_fire = 1'b0;
`endif
  sched_tag_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(wd_fire),
    .din(job_tag), .dout(head), .full(full), .empty(empty), .count(cnt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mul_ins <= '0;
      mul_stb <= 1'b0;
      mode <= TWO_IN;
      res_valid <= 1'b0;
      res_data <= '0;
      res_tag <= '0;
      err <= 1'b0;
      state <= IDLE;
    end else begin
      mul_stb <= push;
      if (push) begin
        mul_ins <= pack_ops(job_nin, job_ops);
        mode <= rmode;
      end
      res_valid <= pop;
      if (pop) begin
        res_data <= tree_out[15:0];
        res_tag <= head;
      end
      err <= (acc && !legal) || stray || wd_fire;
      state <= nxt;
    end
endmodule

// File: tb/tb_mul_tree_sched.sv
// tb_mul_tree_sched: scoreboard bench for mul_tree_sched with directed vectors
module tb_mul_tree_sched;
  logic clk = 0, rst = 1;
  logic job_valid = 0, job_ready;
  logic [2:0] job_nin = 0;
  logic [95:0] job_ops = 0;
  logic [3:0] job_tag = 0;
  logic [127:0] mul_ins;
  logic mul_stb, res_valid, busy, err;
  logic [1:0] mode;
  logic [63:0] tree_out = 0;
  logic [3:0] tree_stbs = 0;
  logic [15:0] res_data;
  logic [3:0] res_tag;
  int nchk = 0, nerr = 0;
  logic [129:0] iss_q[$];
  logic [19:0] res_q[$];
  logic [129:0] ie;
  logic [19:0] re;

  always #5 clk = ~clk;

  mul_tree_sched dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready), .job_nin(job_nin),
    .job_ops(job_ops), .job_tag(job_tag), .mul_ins(mul_ins), .mul_stb(mul_stb), .mode(mode),
    .tree_out(tree_out), .tree_stbs(tree_stbs), .res_valid(res_valid), .res_data(res_data),
    .res_tag(res_tag), .busy(busy), .err(err)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (mul_stb) begin
      if (iss_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_issue: got %h expected no issue", mul_ins);
      end else begin
        ie = iss_q.pop_front();
        chk("issue_ins", mul_ins, ie[129:2]);
        chk("issue_mode", 128'(mode), 128'(ie[1:0]));
      end
    end
    if (res_valid) begin
      if (res_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_result: got %h/%h expected no result", res_data, res_tag);
      end else begin
        re = res_q.pop_front();
        chk("res_data", 128'(res_data), 128'(re[19:4]));
        chk("res_tag", 128'(res_tag), 128'(re[3:0]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic take(input logic [2:0] nin, input logic [127:0] ei, input logic [1:0] em);
    if (nin >= 2 && nin <= 6) iss_q.push_back({ei, em});
    tick;
    job_valid = 0;
  endtask

  task automatic offer(input logic [2:0] nin, input logic [95:0] ops, input logic [3:0] tg,
                       input logic [127:0] ei, input logic [1:0] em, output int w);
    job_valid = 1; job_nin = nin; job_ops = ops; job_tag = tg;
    #1;
    w = 0;
    while (!job_ready && w < 200) begin tick; w++; end
    if (!job_ready) begin
      nchk++; nerr++;
      $display("FAIL offer_timeout: got ready=0 expected ready within 200 cycles");
      job_valid = 0;
    end else take(nin, ei, em);
  endtask

  task automatic strobe(input logic [15:0] d, input logic [3:0] tg, input bit exp);
    tree_stbs = 4'b0011;
    tree_out = {16'hAAAA, 16'hBBBB, 16'hCCCC, d};
    if (exp) res_q.push_back({d, tg});
    tick;
    tree_stbs = 0;
  endtask

  localparam logic [95:0] OPS2 = {64'hDEAD_BEEF_1234_5678, 16'h4040, 16'h4000};
  localparam logic [95:0] OPS3 = {48'hFFFF_FFFF_FFFF, 16'h4000, 16'h4000, 16'h4000};
  localparam logic [95:0] OPS4 = {32'hFFFF_FFFF, 16'h40A0, 16'h4080, 16'h4040, 16'h4000};
  localparam logic [95:0] OPS5 = {16'hEEEE, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
  localparam logic [95:0] OPS6 = {6{16'h4000}};
  localparam logic [127:0] INS2 = {96'd0, 32'h4040_4000};
  localparam logic [127:0] INS3 = {64'd0, 64'h3F80_4000_4000_4000};
  localparam logic [127:0] INS4 = {64'd0, 64'h40A0_4080_4040_4000};
  localparam logic [127:0] INS5 = {48'h3F80_3F80_3F80, 80'h4000_4000_4000_4000_4000};
  localparam logic [127:0] INS6 = {32'h3F80_3F80, 96'h4000_4000_4000_4000_4000_4000};

  initial begin
    int w, wsum, n;
    #2;
    chk("rst_mul_stb", 128'(mul_stb), 0);
    chk("rst_mode", 128'(mode), 0);
    chk("rst_busy", 128'(busy), 0);
    @(negedge clk) rst = 0;
    tick;
    offer(3'd2, OPS2, 4'd3, INS2, 2'd0, w);
    strobe(16'h40C0, 4'd3, 1);
    offer(3'd3, OPS3, 4'd5, INS3, 2'd2, w);
    strobe(16'h4100, 4'd5, 1);
    offer(3'd4, OPS4, 4'd1, INS4, 2'd2, w);
    offer(3'd4, OPS4, 4'd2, INS4, 2'd2, w);
    chk("b2b_no_stall", 128'(w), 0);
    job_valid = 1; job_nin = 3'd6; job_ops = OPS6; job_tag = 4'd3;
    #1;
    chk("drain_ready_lo", 128'(job_ready), 0);
    tick;
    chk("drain_hold", 128'(job_ready), 0);
    chk("drain_busy", 128'(busy), 1);
    strobe(16'h4110, 4'd1, 1);
    #1;
    chk("drain_one_left", 128'(job_ready), 0);
    strobe(16'h4120, 4'd2, 1);
    #1;
    chk("drain_ready_back", 128'(job_ready), 1);
    take(3'd6, INS6, 2'd3);
    strobe(16'h4200, 4'd3, 1);
    wsum = 0;
    for (int i = 0; i < 16; i++) begin
      offer(3'd6, OPS6, 4'(i), INS6, 2'd3, w);
      wsum += w;
    end
    chk("fill_no_stall", 128'(wsum), 0);
    job_valid = 1; job_nin = 3'd6; job_ops = OPS6; job_tag = 4'd10;
    #1;
    chk("full_ready_lo", 128'(job_ready), 0);
    tree_stbs = 4'b0001;
    tree_out = {48'h0, 16'h4300};
    res_q.push_back({16'h4300, 4'd0});
    #1;
    chk("full_retire_same_cycle", 128'(job_ready), 0);
    tick;
    tree_stbs = 0;
    chk("ready_after_retire", 128'(job_ready), 1);
    take(3'd6, INS6, 2'd3);
    for (int i = 1; i < 16; i++) strobe(16'h4300 + 16'(i), 4'(i), 1);
    strobe(16'h43F0, 4'd10, 1);
    chk("drained_busy", 128'(busy), 0);
    job_valid = 1; job_nin = 3'd7; job_ops = OPS6; job_tag = 4'd4;
    #1;
    chk("illegal_ready", 128'(job_ready), 1);
    take(3'd7, 128'd0, 2'd0);
    chk("illegal_err", 128'(err), 1);
    chk("illegal_no_busy", 128'(busy), 0);
    tick;
    chk("err_one_cycle", 128'(err), 0);
    strobe(16'h1234, 4'd0, 0);
    chk("stray_err", 128'(err), 1);
    tick;
    chk("stray_err_clear", 128'(err), 0);
    for (int i = 1; i <= 5; i++) offer(3'd5, OPS5, 4'(i), INS5, 2'd3, w);
    #1 rst = 1;
    #1;
    chk("arst_mul_ins", mul_ins, 0);
    chk("arst_mul_stb", 128'(mul_stb), 0);
    chk("arst_mode", 128'(mode), 0);
    chk("arst_res_valid", 128'(res_valid), 0);
    chk("arst_res_data", 128'(res_data), 0);
    chk("arst_res_tag", 128'(res_tag), 0);
    chk("arst_busy", 128'(busy), 0);
    chk("arst_err", 128'(err), 0);
    iss_q.delete();
    #3 rst = 0;
    tick;
    chk("post_rst_busy", 128'(busy), 0);
    offer(3'd2, OPS2, 4'd7, INS2, 2'd0, w);
    strobe(16'h4444, 4'd7, 1);
`ifdef MUL_TREE_SCHED_WDOG_EN
    offer(3'd2, OPS2, 4'd9, INS2, 2'd0, w);
    n = 0;
    while (!err && n < 100) begin tick; n++; end
    chk("wdog_cycles", 128'(n), 64);
    chk("wdog_busy", 128'(busy), 0);
`endif
    repeat (3) tick;
    chk("iss_q_empty", 128'(iss_q.size()), 0);
    chk("res_q_empty", 128'(res_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
